icache_refill: RTL and testbench

- Line-fill engine directly upstream of the instruction cache.
- On a cache miss it fetches the 4 words of the missing 16-byte line from instruction memory, one word per req/ack transaction.
- It assembles the words into a 128-bit line and presents it to the cache with a one-cycle valid strobe plus the line address.
- It also tells the PC stage it is busy, so the PC stays stalled until the fill lands.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_refill_if.sv | 28 ++
 rtl/icache_line_asm.sv | 30 +++
 rtl/icache_refill.sv | 132 +++++++++++++
 tb/tb_icache_refill.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helpers for the I-cache line-fill engine.
package icache_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int WORDS       = 4;
    localparam int LINE_W      = WORDS * WORD_W;
    localparam int OFFSET_BITS = 4;
    localparam int LB_W        = ADDR_W - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } refill_state_e;

    // Line base is the {tag,index} part of a byte address.
    function automatic logic [LB_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return LB_W'(addr >> OFFSET_BITS);
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Miss / memory / fill signal bundle between the refill engine, the cache and instruction memory.
interface icache_refill_if;
    import icache_pkg::*;

    logic                miss;
    logic [ADDR_W-1:0]   miss_addr;
    logic                flush;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [WORD_W-1:0]   mem_rdata;
    logic                fill_valid;
    logic [LINE_W-1:0]   fill_line;
    logic [ADDR_W-1:0]   fill_addr;
    logic                busy;
    logic                timeout;

    modport slave (
        input  miss, miss_addr, flush, mem_ack, mem_rdata,
        output mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy, timeout
    );

    modport master (
        output miss, miss_addr, flush, mem_ack, mem_rdata,
        input  mem_req, mem_addr, fill_valid, fill_line, fill_addr, busy, timeout
    );

endinterface

// File: rtl/icache_line_asm.sv
// 4 x 32-bit line assembly register; slot k lands at bits [32k+31:32k], cleared on abort.
module icache_line_asm
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [WORDS-1:0]  we_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [LINE_W-1:0] line_o
);

    logic [WORDS-1:0][WORD_W-1:0] slot_q;

    // Per-slot capture of returned words; abort wipes any partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (we_i[i]) slot_q[i] <= wdata_i;
            end
        end
    end

    assign line_o = slot_q;

endmodule

// File: rtl/icache_refill.sv
// I-cache line-fill engine: fetches the 4 words of a missing line, one req/ack at a time,
// and strobes the assembled line into the cache.
// Build option: ICACHE_REFILL_CWF_EN fetches the critical (missed) word first, wrapping mod 4.
//
// state | meaning
// IDLE  | waiting for a miss
// REQ   | word request outstanding on the memory port
// DONE  | one-cycle fill strobe to the cache
module icache_refill
    import icache_pkg::*;
#(
    parameter int MEM_LAT_MAX = 255
)
(
    input  logic            clk,
    input  logic            rst_n,
    icache_refill_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]        state_q, state_d;
    logic [LB_W-1:0]   base_q, base_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        lat_q, lat_d;
    logic              to_q, to_d;
    logic              take;
    logic              abort;
    logic [1:0]        start_word;
    logic [WORDS-1:0]  we;
    logic [LINE_W-1:0] line;

`ifdef ICACHE_REFILL_CWF_EN
    assign start_word = bus.miss_addr[3:2];
`else
    assign start_word = 2'b00;
`endif

    // Next-state, word bookkeeping, latency watchdog; flush beats a same-cycle ack.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        to_d    = to_q;
        take    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.miss && !bus.flush) begin
                    state_d = S_REQ;
                    base_d  = line_base(bus.miss_addr);
                    k_d     = start_word;
                    cnt_d   = 2'd0;
                    lat_d   = 8'd0;
                end
            end
            S_REQ: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end else if (bus.mem_ack) begin
                    take  = 1'b1;
                    k_d   = k_q + 2'd1;
                    cnt_d = cnt_q + 2'd1;
                    lat_d = 8'd0;
                    if (cnt_q == 2'(WORDS - 1)) state_d = S_DONE;
                end else if (lat_q == 8'(MEM_LAT_MAX - 1)) begin
                    to_d    = 1'b1;
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-hot slot write enable for the word being acknowledged.
    always_comb begin
        we = '0;
        if (take) we[k_q] = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            to_q    <= to_d;
        end
    end

    icache_line_asm u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (abort),
        .we_i    (we),
        .wdata_i (bus.mem_rdata),
        .line_o  (line)
    );

    assign bus.mem_req    = (state_q == S_REQ);
    assign bus.mem_addr   = {base_q, k_q, 2'b00};
    // A flush landing in DONE suppresses the strobe, so a dropped line never reaches the cache.
    assign bus.fill_valid = (state_q == S_DONE) && !bus.flush;
    assign bus.fill_line  = line;
    assign bus.fill_addr  = {base_q, {OFFSET_BITS{1'b0}}};
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.timeout    = to_q;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus pushes expected requests and lines,
// a memory responder and a fill monitor pop and compare.
module tb_icache_refill;
    import icache_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
        int           due;
    } fill_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] salt;
    logic [31:0] exp_addr_q[$];
    int          dly_q[$];
    fill_t       fill_q[$];
    int          f_at = 0;
    int          ack_n = 0;
    int          last_miss = 0;
    bit          spur_en = 1'b0;

    icache_refill_if bus();

    icache_refill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: event seen but none expected (cycle %0d)", nm, cyc);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_mem_req"},    bus.mem_req,    0);
        chk({tag, "_mem_addr"},   bus.mem_addr,   0);
        chk({tag, "_fill_valid"}, bus.fill_valid, 0);
        chk({tag, "_fill_line"},  bus.fill_line,  0);
        chk({tag, "_fill_addr"},  bus.fill_addr,  0);
        chk({tag, "_busy"},       bus.busy,       0);
        chk({tag, "_timeout"},    bus.timeout,    0);
    endtask

    // Reference: a miss on addr issues nreq word requests starting at the start word and
    // wrapping mod 4; a full fill returns word k = (line_addr + 4k) ^ salt and strobes
    // 9 cycles + total ack delay after the miss cycle (10 cycles inclusive when no delay).
    task automatic issue_miss(input logic [31:0] addr, input int d[4], input int nreq,
                              input bit want_fill, input int flush_at);
        logic [27:0] base;
        logic [1:0]  s;
        logic [1:0]  w;
        int          sum;
        fill_t       f;
        base = addr[31:4];
`ifdef ICACHE_REFILL_CWF_EN
        s = addr[3:2];
`else
        s = 2'd0;
`endif
        sum = 0;
        for (int i = 0; i < nreq; i++) begin
            w = s + 2'(i);
            exp_addr_q.push_back({base, w, 2'b00});
            dly_q.push_back(d[i]);
            sum += d[i];
        end
        if (want_fill) begin
            f.addr = {base, 4'h0};
            for (int k = 0; k < 4; k++) begin
                w = 2'(k);
                f.line[32*k +: 32] = {base, w, 2'b00} ^ salt;
            end
            f.due = cyc + 9 + sum;
            fill_q.push_back(f);
        end
        ack_n         = 0;
        f_at          = flush_at;
        last_miss     = cyc;
        bus.miss      = 1'b1;
        bus.miss_addr = addr;
    endtask

    task automatic finish_fill();
        int n;
        @(negedge clk);
        bus.miss = 1'b0;
        chk("busy_during_fill", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            bus.miss_addr = $urandom;
            n++;
        end
        chk("fill_completes", bus.busy, 0);
    endtask

    // Memory responder: checks request order and hold-while-waiting, acks after the
    // queued delay, optionally raises flush on the selected ack.
    initial begin : mem_model
        int          wait_left;
        logic [31:0] req_addr;
        bit          fl_drv;
        wait_left = -1;
        req_addr  = '0;
        fl_drv    = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (fl_drv) begin
                bus.flush = 1'b0;
                fl_drv    = 1'b0;
            end
            if (!rst_n || !bus.mem_req) begin
                wait_left = -1;
                if (rst_n && spur_en) bus.mem_ack = 1'($urandom_range(0, 1));
            end else if (wait_left < 0) begin
                req_addr = bus.mem_addr;
                if (exp_addr_q.size() == 0) fail_now("mem_req_unexpected");
                else chk("mem_addr_order", bus.mem_addr, exp_addr_q.pop_front());
                wait_left = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            end else begin
                chk("mem_addr_hold", bus.mem_addr, req_addr);
                if (wait_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ salt;
                    wait_left     = -1;
                    ack_n++;
                    if (ack_n == f_at) begin
                        bus.flush = 1'b1;
                        fl_drv    = 1'b1;
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Fill monitor: every strobe must match the oldest expected line, on its due cycle.
    initial begin : fill_mon
        fill_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.fill_valid) begin
                if (fill_q.size() == 0) begin
                    fail_now("fill_unexpected");
                end else begin
                    e = fill_q.pop_front();
                    chk("fill_addr",  bus.fill_addr, e.addr);
                    chk("fill_line",  bus.fill_line, e.line);
                    chk("fill_cycle", cyc,           e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: bench did not reach its end (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d0[4];
        int d[4];
        int j;
        d0 = '{0, 0, 0, 0};
        bus.miss      = 1'b0;
        bus.miss_addr = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        salt          = 32'hA5A5_A5A5;

        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // basic fill, then the same line with ack delays 0/3/7/1
        issue_miss(32'h0040_0128, d0, 4, 1'b1, 0);
        finish_fill();
        issue_miss(32'h0040_0128, '{0, 3, 7, 1}, 4, 1'b1, 0);
        finish_fill();

        // miss together with flush is ignored
        bus.miss      = 1'b1;
        bus.flush     = 1'b1;
        bus.miss_addr = 32'h0000_0440;
        @(negedge clk);
        chk("miss_flush_busy", bus.busy, 0);
        chk("miss_flush_req",  bus.mem_req, 0);
        bus.miss  = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);

        // flush on the 4th ack drops the line; next miss one cycle later is normal
        issue_miss(32'h0000_2A34, d0, 4, 1'b0, 4);
        finish_fill();
        chk("flush_idle_cycle", cyc, last_miss + 9);
        chk("flush_mem_req", bus.mem_req, 0);
        issue_miss(32'h0000_2A34, d0, 4, 1'b1, 0);
        finish_fill();

        // randomized fills with random delays, flushes and stray acks while idle
        spur_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            salt = $urandom;
            foreach (d[i]) d[i] = $urandom_range(0, 5);
            j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            issue_miss($urandom, d, (j != 0) ? j : 4, j == 0, j);
            finish_fill();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        spur_en = 1'b0;

        // memory never answers: sticky timeout after 255 cycles in REQ
        issue_miss(32'h1234_5678, '{1000, 0, 0, 0}, 1, 1'b0, 0);
        @(negedge clk);
        bus.miss = 1'b0;
        while (cyc < last_miss + 255) @(negedge clk);
        chk("timeout_early",     bus.timeout, 0);
        chk("timeout_busy_wait", bus.busy,    1);
        @(negedge clk);
        chk("timeout_set",  bus.timeout, 1);
        chk("timeout_req",  bus.mem_req, 0);
        chk("timeout_busy", bus.busy,    0);
        repeat (10) @(negedge clk);
        chk("timeout_sticky", bus.timeout, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_idle_zero("rst_timeout");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // reset right after the 2nd ack: outputs clear at once, no line ever emitted
        salt = 32'hA5A5_A5A5;
        issue_miss(32'h0040_0128, d0, 2, 1'b0, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        bus.miss = 1'b0;
        #1 chk_idle_zero("rst_mid");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_fill", bus.fill_valid, 0);
        chk("rst_mid_idle",    bus.busy,       0);

        chk("req_queue_drained",  exp_addr_q.size(), 0);
        chk("fill_queue_drained", fill_q.size(),     0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
